// File: rtl/branch_resolve_predict_pkg.sv
// Shared types and helpers for the EX-stage branch resolver and its direction table.
// Encodes the branch direction rules and the 2-bit saturating counter step.
package otter_br_pkg;

  typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} bht_state_t;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // Returns {taken, illegal}; 010/011 are not branch encodings.
  function automatic logic [1:0] br_taken(input logic [2:0] f3, input logic eq,
                                          input logic lt, input logic ltu);
    logic [1:0] r;
    case (f3)
      BEQ:     r = {eq,   1'b0};
      BNE:     r = {~eq,  1'b0};
      BLT:     r = {lt,   1'b0};
      BGE:     r = {~lt,  1'b0};
      BLTU:    r = {ltu,  1'b0};
      BGEU:    r = {~ltu, 1'b0};
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  function automatic bht_state_t bht_next(input bht_state_t s, input logic taken);
    bht_state_t n;
    case (s)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      default: n = taken ? ST  : WT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_resolve_predict_if.sv
// Fetch lookup, EX branch operands and resolver outputs bundled as one port.
interface branch_resolve_predict_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_funct3;
  logic        ex_pred_taken;
  logic [31:0] ex_target;
  logic        br_eq;
  logic        br_lt;
  logic        br_ltu;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        illegal_br;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_funct3, ex_pred_taken, ex_target,
           br_eq, br_lt, br_ltu,
    input  pred_taken, flush, redirect_pc, illegal_br, branch_cnt, mispred_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_funct3, ex_pred_taken, ex_target,
           br_eq, br_lt, br_ltu,
    output pred_taken, flush, redirect_pc, illegal_br, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_predict_bht_table.sv
// Table of 2-bit direction counters: async read for fetch, counter step on write.
// Read-before-write: a same-index read in the update cycle sees the old state.
module bht_table
  import otter_br_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output bht_state_t       o_rd_state,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_taken
);

  bht_state_t r_cnt [BHT_ENTRIES];

  assign o_rd_state = r_cnt[i_rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_cnt[i] <= WNT;
    end else if (i_we) begin
      r_cnt[i_wr_idx] <= bht_next(r_cnt[i_wr_idx], i_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_predict.sv
// EX-stage branch resolver: direction decode, mispredict flush/redirect,
// direction-table training and branch statistics.
module branch_resolve_predict
  import otter_br_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic                    CLK,
  input  logic                    RST,
  branch_resolve_predict_if.slave bus
);

  logic        r_flush;
  logic [31:0] r_redirect_pc;
  logic        r_illegal_br;
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  logic        w_res;
  logic        w_taken;
  logic        w_illegal;
  logic        w_upd;
  logic        w_mis;
  bht_state_t  w_rd_state;
  logic        w_unused_pc_bits;

  // The instruction in EX while flush is high is on the squashed path.
  assign w_res = bus.ex_valid & ~r_flush;
  assign {w_taken, w_illegal} = br_taken(bus.ex_funct3, bus.br_eq, bus.br_lt, bus.br_ltu);
  assign w_upd = w_res & ~w_illegal;
  assign w_mis = w_taken ^ bus.ex_pred_taken;

  assign w_unused_pc_bits = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0]};

  bht_table #(.BHT_ENTRIES(BHT_ENTRIES), .IDX_W(IDX_W)) u_bht (
    .clk        (CLK),
    .rst        (RST),
    .i_rd_idx   (bus.if_pc[IDX_W+1:2]),
    .o_rd_state (w_rd_state),
    .i_we       (w_upd),
    .i_wr_idx   (bus.ex_pc[IDX_W+1:2]),
    .i_taken    (w_taken)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_flush       <= 1'b0;
      r_redirect_pc <= 32'd0;
      r_illegal_br  <= 1'b0;
      r_branch_cnt  <= 32'd0;
      r_mispred_cnt <= 32'd0;
    end else begin
      r_flush      <= w_upd & w_mis;
      r_illegal_br <= w_res & w_illegal;
      if (w_upd) begin
        r_redirect_pc <= w_taken ? bus.ex_target : bus.ex_pc + 32'd4;
        r_branch_cnt  <= r_branch_cnt + 32'd1;
        if (w_mis) r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
    end
  end

  assign bus.pred_taken  = w_rd_state[1];
  assign bus.flush       = r_flush;
  assign bus.redirect_pc = r_redirect_pc;
  assign bus.illegal_br  = r_illegal_br;
  assign bus.branch_cnt  = r_branch_cnt;
  assign bus.mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Scoreboard bench: the driver runs a per-PC counter model on raw operands and
// queues expectations; two monitors compare registered outputs and fetch predictions.
module tb_branch_resolve_predict;
  import otter_br_pkg::*;

  localparam int N = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_predict_if bus();

  branch_resolve_predict #(.BHT_ENTRIES(N)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic        flush;
    logic [31:0] rd;
    logic        ill;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];
  logic qp[$];
  int   checks = 0;
  int   errors = 0;

  int          m_cnt [N];
  logic        m_flush, m_ill;
  logic [31:0] m_rd, m_bc, m_mc;
  bit          m_known = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(N));
  endfunction

  // One clock of stimulus; operands a/b stand in for the register values BRANCH_COND compared.
  task automatic cyc(input bit r, input logic [31:0] ipc, input bit v, input logic [31:0] pc,
                     input logic [2:0] f3, input bit pred, input logic [31:0] tgt,
                     input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   taken, ill, res;
    int   i;
    @(negedge clk);
    rst               = r;
    bus.if_pc         = ipc;
    bus.ex_valid      = v;
    bus.ex_pc         = pc;
    bus.ex_funct3     = f3;
    bus.ex_pred_taken = pred;
    bus.ex_target     = tgt;
    bus.br_eq         = (a == b);
    bus.br_lt         = ($signed(a) < $signed(b));
    bus.br_ltu        = (a < b);
    if (m_known) qp.push_back(m_cnt[idx_of(ipc)] >= 2);
    if (r) begin
      foreach (m_cnt[k]) m_cnt[k] = 1;
      m_flush = 0; m_ill = 0; m_rd = 0; m_bc = 0; m_mc = 0;
      m_known = 1'b1;
    end else begin
      res = v && !m_flush;
      ill = (f3 == 3'b010) || (f3 == 3'b011);
      case (f3)
        3'd0:    taken = (a == b);
        3'd1:    taken = (a != b);
        3'd4:    taken = ($signed(a) < $signed(b));
        3'd5:    taken = ($signed(a) >= $signed(b));
        3'd6:    taken = (a < b);
        3'd7:    taken = (a >= b);
        default: taken = 0;
      endcase
      m_flush = 0;
      m_ill   = res && ill;
      if (res && !ill) begin
        m_flush = (taken != pred);
        m_rd    = taken ? tgt : pc + 32'd4;
        m_bc    = m_bc + 1;
        if (m_flush) m_mc = m_mc + 1;
        i = idx_of(pc);
        m_cnt[i] = taken ? ((m_cnt[i] == 3) ? 3 : m_cnt[i] + 1)
                         : ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1);
      end
    end
    e = '{m_flush, m_rd, m_ill, m_bc, m_mc};
    q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] ipc);
    cyc(0, ipc, 0, 32'd0, 3'd0, 0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("flush",       32'(bus.flush),      32'(e.flush));
        chk("redirect_pc", bus.redirect_pc,     e.rd);
        chk("illegal_br",  32'(bus.illegal_br), 32'(e.ill));
        chk("branch_cnt",  bus.branch_cnt,      e.bc);
        chk("mispred_cnt", bus.mispred_cnt,     e.mc);
      end
    end
  end

  initial begin
    logic p;
    forever begin
      @(negedge clk); #1;
      if (qp.size() > 0) begin
        p = qp.pop_front();
        chk("pred_taken", 32'(bus.pred_taken), 32'(p));
      end
    end
  end

  logic [31:0] pcs [8];

  initial begin
    logic [31:0] a, b, pc, ipc;
    rst = 1'b1;
    bus.if_pc = 0; bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_funct3 = 0;
    bus.ex_pred_taken = 0; bus.ex_target = 0;
    bus.br_eq = 0; bus.br_lt = 0; bus.br_ltu = 0;

    cyc(1, 32'h0, 0, 32'h0, 3'd0, 0, 32'h0, 32'h0, 32'h0);
    // taken BEQ trains WNT -> WT -> ST -> ST, first one mispredicts
    cyc(0, 32'h40, 1, 32'h40, BEQ, 0, 32'h80, 32'd5, 32'd5);
    idle(32'h40);
    cyc(0, 32'h40, 1, 32'h40, BEQ, 1, 32'h80, 32'd5, 32'd5);
    idle(32'h40);
    cyc(0, 32'h40, 1, 32'h40, BEQ, 1, 32'h80, 32'd5, 32'd5);
    idle(32'h40);
    // BGEU not taken with fall-through wrapping past 2^32
    cyc(0, 32'h0, 1, 32'hFFFF_FFFC, BGEU, 1, 32'h10, 32'd1, 32'd2);
    idle(32'h0);
    // mispredict followed by a held EX slot that must be ignored
    cyc(0, 32'h200, 1, 32'h200, BNE, 1, 32'h300, 32'd7, 32'd7);
    cyc(0, 32'h200, 1, 32'h200, BNE, 1, 32'h300, 32'd7, 32'd7);
    idle(32'h200);
    // illegal funct3
    cyc(0, 32'h44, 1, 32'h44, 3'b010, 1, 32'h90, 32'd1, 32'd1);
    idle(32'h44);
    cyc(0, 32'h48, 1, 32'h48, 3'b011, 0, 32'h90, 32'd1, 32'd2);
    idle(32'h48);
    // same-index read and write: old value visible this cycle
    cyc(0, 32'h100, 1, 32'h100, BEQ, 1, 32'h180, 32'd3, 32'd3);
    idle(32'h100);
    // reset wins over a mispredicting resolve
    cyc(1, 32'h40, 1, 32'h40, BNE, 1, 32'h80, 32'd4, 32'd4);
    for (int k = 0; k < N; k++) idle(32'(k * 4));

    for (int k = 0; k < 8; k++) pcs[k] = 32'(($urandom_range(0, N - 1)) * 4 + ($urandom_range(0, 1) * 256));
    for (int n = 0; n < 3000; n++) begin
      a = $urandom;
      case ($urandom_range(0, 2))
        0: b = a;
        1: b = $urandom;
        default: b = a ^ (32'h1 << $urandom_range(0, 31));
      endcase
      pc  = pcs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      ipc = ($urandom_range(0, 3) == 0) ? pc : pcs[$urandom_range(0, 7)];
      cyc(($urandom_range(0, 499) == 0), ipc, ($urandom_range(0, 9) < 7), pc,
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, a, b);
    end

    idle(32'h0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0 || qp.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending expected 0/0", q.size(), qp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
